// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
//   WORD_SIZE   : stall statistics counter width
//   WAIT_CNT_W  : memory-wait counter width (timeout at all-ones)
//   state_e     : sequencer states
//   ctrl_t      : bundle of stall/flush/pc-enable controls driven to the pipeline
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned REG_ADDR_W = 2;

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = {WAIT_CNT_W{1'b1}};
  localparam logic [WORD_SIZE-1:0]  STALL_MAX = {WORD_SIZE{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_D_WAIT = 2'd1,
    ST_I_WAIT = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  typedef struct packed {
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic stall_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic pc_write_en;
  } ctrl_t;

  // Control patterns, one per priority level
  localparam ctrl_t CTRL_RESET    = ctrl_t'(7'b0000_110);
  localparam ctrl_t CTRL_FREEZE   = ctrl_t'(7'b1111_000);
  localparam ctrl_t CTRL_REDIRECT = ctrl_t'(7'b0000_111);
  localparam ctrl_t CTRL_BUBBLE   = ctrl_t'(7'b1000_010);
  localparam ctrl_t CTRL_IMISS    = ctrl_t'(7'b0000_100);
  localparam ctrl_t CTRL_RUN      = ctrl_t'(7'b0000_001);

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
//   rs_id/rt_id, use_rs/use_rt : ID source registers and their read enables
//   load_ex, reg_write_ex      : EX instruction is a load that writes the RF
//   wr_ex                      : EX destination register
//   load_use_c                 : hazard present (combinational)
module pipeline_hazard_ctrl_load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  use_rs,
  input  logic                  use_rt,
  input  logic                  load_ex,
  input  logic                  reg_write_ex,
  input  logic [REG_ADDR_W-1:0] wr_ex,
  output logic                  load_use_c
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit     = use_rs & (rs_id == wr_ex);
  assign rt_hit     = use_rt & (rt_id == wr_ex);
  assign load_use_c = load_ex & reg_write_ex & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Resolves load-use hazards,
// EX mispredicts, I/D memory waits and HALT drain; keeps debug statistics.
//   Inputs : hazard sources from ID/EX/MEM/WB and memory handshakes
//   Outputs: stall_*/flush_*/pc_write_en (combinational from state + inputs),
//            halted, mem_timeout_err (sticky), stall_cycles (saturating)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs_ID,
  input  logic [REG_ADDR_W-1:0] rt_ID,
  input  logic                  use_rs_ID,
  input  logic                  use_rt_ID,
  input  logic                  d_readM_EX,
  input  logic                  RegWrite_EX,
  input  logic [REG_ADDR_W-1:0] write_reg_addr_EX,
  input  logic                  mispredict_EX,
  input  logic                  i_req,
  input  logic                  i_ready,
  input  logic                  d_req_MEM,
  input  logic                  d_ready,
  input  logic                  is_halted_WB,
  output logic                  stall_IF_ID,
  output logic                  stall_ID_EX,
  output logic                  stall_EX_MEM,
  output logic                  stall_MEM_WB,
  output logic                  flush_IF_ID,
  output logic                  flush_ID_EX,
  output logic                  pc_write_en,
  output logic                  halted,
  output logic                  mem_timeout_err,
  output logic [WORD_SIZE-1:0]  stall_cycles
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WORD_SIZE-1:0]  stall_cnt_q, stall_cnt_d;
  logic                  timeout_q, timeout_d;

  logic  load_use;
  logic  dmiss;
  logic  imiss;
  logic  in_wait_q;
  logic  in_wait_d;
  ctrl_t ctrl_run;
  ctrl_t ctrl_out;

  pipeline_hazard_ctrl_load_use_detect u_load_use_detect (
    .rs_id        (rs_ID),
    .rt_id        (rt_ID),
    .use_rs       (use_rs_ID),
    .use_rt       (use_rt_ID),
    .load_ex      (d_readM_EX),
    .reg_write_ex (RegWrite_EX),
    .wr_ex        (write_reg_addr_EX),
    .load_use_c   (load_use)
  );

  // A completing access in the same cycle is not a miss
  assign dmiss = d_req_MEM & ~d_ready;
  assign imiss = i_req & ~i_ready;

  // Output priority mux (reset override applied separately)
  always_comb begin : out_mux
    ctrl_run = CTRL_RUN;
    if (state_q == ST_HALT) begin
      ctrl_run = CTRL_FREEZE;
    end else if (dmiss) begin
      ctrl_run = CTRL_FREEZE;
    end else if (mispredict_EX) begin
      ctrl_run = CTRL_REDIRECT;
    end else if (load_use) begin
      ctrl_run = CTRL_BUBBLE;
    end else if (imiss) begin
      ctrl_run = CTRL_IMISS;
    end
  end

  // While reset is held the pipeline registers are flushed and the PC frozen
  assign ctrl_out     = reset_n ? ctrl_run : CTRL_RESET;
  assign stall_IF_ID  = ctrl_out.stall_if_id;
  assign stall_ID_EX  = ctrl_out.stall_id_ex;
  assign stall_EX_MEM = ctrl_out.stall_ex_mem;
  assign stall_MEM_WB = ctrl_out.stall_mem_wb;
  assign flush_IF_ID  = ctrl_out.flush_if_id;
  assign flush_ID_EX  = ctrl_out.flush_id_ex;
  assign pc_write_en  = ctrl_out.pc_write_en;

  assign in_wait_q = (state_q == ST_D_WAIT) | (state_q == ST_I_WAIT);
  assign in_wait_d = (state_d == ST_D_WAIT) | (state_d == ST_I_WAIT);

  // Next state, wait counter and statistics
  always_comb begin : next_state
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_RUN: begin
        if (dmiss) begin
          state_d = ST_D_WAIT;
        end else if (imiss) begin
          state_d = ST_I_WAIT;
        end
      end
      ST_D_WAIT: begin
        if (d_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_I_WAIT: begin
        // A mispredict redirects the PC, so the pending fetch is abandoned
        if (dmiss) begin
          state_d = ST_D_WAIT;
        end else if (i_ready | mispredict_EX) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_HALT;
    endcase

    if (is_halted_WB) begin
      state_d = ST_HALT;
    end

    // Counter restarts on entry to a wait state, including I_WAIT -> D_WAIT
    if (in_wait_d && (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (in_wait_q && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
    end

    if (wait_cnt_d == WAIT_MAX) begin
      timeout_d = 1'b1;
    end

    if ((state_q != ST_HALT) && !ctrl_run.pc_write_en && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + WORD_SIZE'(1);
    end
  end

  // State and statistics registers
  always_ff @(posedge clk or negedge reset_n) begin : regs
    if (!reset_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign halted          = (state_q == ST_HALT);
  assign mem_timeout_err = timeout_q;
  assign stall_cycles    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic compared against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  rs_ID, rt_ID, write_reg_addr_EX;
  logic        use_rs_ID, use_rt_ID, d_readM_EX, RegWrite_EX, mispredict_EX;
  logic        i_req, i_ready, d_req_MEM, d_ready, is_halted_WB;
  logic        stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic        flush_IF_ID, flush_ID_EX, pc_write_en, halted, mem_timeout_err;
  logic [15:0] stall_cycles;
  logic [6:0]  ctrl_obs;

  int n_chk = 0;
  int n_bad = 0;

  // Behavioural model state
  bit m_halt, m_dwait, m_iwait, m_err;
  int m_wait, m_stalls;

  pipeline_hazard_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rs_ID             (rs_ID),
    .rt_ID             (rt_ID),
    .use_rs_ID         (use_rs_ID),
    .use_rt_ID         (use_rt_ID),
    .d_readM_EX        (d_readM_EX),
    .RegWrite_EX       (RegWrite_EX),
    .write_reg_addr_EX (write_reg_addr_EX),
    .mispredict_EX     (mispredict_EX),
    .i_req             (i_req),
    .i_ready           (i_ready),
    .d_req_MEM         (d_req_MEM),
    .d_ready           (d_ready),
    .is_halted_WB      (is_halted_WB),
    .stall_IF_ID       (stall_IF_ID),
    .stall_ID_EX       (stall_ID_EX),
    .stall_EX_MEM      (stall_EX_MEM),
    .stall_MEM_WB      (stall_MEM_WB),
    .flush_IF_ID       (flush_IF_ID),
    .flush_ID_EX       (flush_ID_EX),
    .pc_write_en       (pc_write_en),
    .halted            (halted),
    .mem_timeout_err   (mem_timeout_err),
    .stall_cycles      (stall_cycles)
  );

  assign ctrl_obs = {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                     flush_IF_ID, flush_ID_EX, pc_write_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {stall IF/ID, ID/EX, EX/MEM, MEM/WB, flush IF/ID, ID/EX, pc_we}
  function automatic logic [6:0] exp_ctrl();
    bit lu;
    lu = d_readM_EX && RegWrite_EX &&
         ((use_rs_ID && rs_ID == write_reg_addr_EX) || (use_rt_ID && rt_ID == write_reg_addr_EX));
    if (m_halt)                   return 7'b1111_000;
    if (d_req_MEM && !d_ready)    return 7'b1111_000;
    if (mispredict_EX)            return 7'b0000_111;
    if (lu)                       return 7'b1000_010;
    if (i_req && !i_ready)        return 7'b0000_100;
    return 7'b0000_001;
  endfunction

  // Advance the model by one clock edge using the current inputs
  task automatic model_step();
    logic [6:0] e;
    bit dmiss, imiss, restart, was_wait;
    e        = exp_ctrl();
    dmiss    = d_req_MEM && !d_ready;
    imiss    = i_req && !i_ready;
    restart  = 1'b0;
    was_wait = m_dwait || m_iwait;
    if (!m_halt && !e[0] && m_stalls < 65535) m_stalls++;
    if (m_halt || is_halted_WB) begin
      m_halt = 1'b1; m_dwait = 1'b0; m_iwait = 1'b0;
    end else if (m_dwait) begin
      if (d_ready) m_dwait = 1'b0;
    end else if (m_iwait) begin
      if (dmiss) begin
        m_iwait = 1'b0; m_dwait = 1'b1; restart = 1'b1;
      end else if (i_ready || mispredict_EX) begin
        m_iwait = 1'b0;
      end
    end else if (dmiss) begin
      m_dwait = 1'b1; restart = 1'b1;
    end else if (imiss) begin
      m_iwait = 1'b1; restart = 1'b1;
    end
    if (restart) m_wait = 0;
    else if (was_wait && m_wait < 15) m_wait++;
    if (m_wait == 15) m_err = 1'b1;
  endtask

  task automatic model_reset();
    m_halt = 1'b0; m_dwait = 1'b0; m_iwait = 1'b0; m_err = 1'b0;
    m_wait = 0; m_stalls = 0;
  endtask

  task automatic idle_inputs();
    rs_ID = 2'd0; rt_ID = 2'd0; write_reg_addr_EX = 2'd0;
    use_rs_ID = 1'b0; use_rt_ID = 1'b0; d_readM_EX = 1'b0; RegWrite_EX = 1'b0;
    mispredict_EX = 1'b0; i_req = 1'b0; i_ready = 1'b0;
    d_req_MEM = 1'b0; d_ready = 1'b0; is_halted_WB = 1'b0;
  endtask

  task automatic rand_inputs();
    rs_ID             = 2'($urandom_range(0, 3));
    rt_ID             = 2'($urandom_range(0, 3));
    write_reg_addr_EX = 2'($urandom_range(0, 3));
    use_rs_ID         = 1'($urandom_range(0, 1));
    use_rt_ID         = 1'($urandom_range(0, 1));
    d_readM_EX        = ($urandom_range(0, 2) == 0);
    RegWrite_EX       = ($urandom_range(0, 3) != 0);
    mispredict_EX     = ($urandom_range(0, 9) == 0);
    i_req             = ($urandom_range(0, 9) < 7);
    i_ready           = ($urandom_range(0, 9) < 6);
    d_req_MEM         = ($urandom_range(0, 3) == 0);
    d_ready           = 1'($urandom_range(0, 1));
    is_halted_WB      = ($urandom_range(0, 99) == 0);
  endtask

  // Compare all outputs against the model mid-cycle
  task automatic probe(input string tag);
    #4;
    check_eq({tag, "_ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl()));
    check_eq({tag, "_halted"}, 32'(halted), 32'(m_halt));
    check_eq({tag, "_err"}, 32'(mem_timeout_err), 32'(m_err));
    check_eq({tag, "_stalls"}, 32'(stall_cycles), 32'(m_stalls));
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_check(input string tag);
    probe(tag);
    advance();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react without a clock edge
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq({tag, "_rst_ctrl"}, 32'(ctrl_obs), 32'b0000_110);
    check_eq({tag, "_rst_stalls"}, 32'(stall_cycles), 32'd0);
    check_eq({tag, "_rst_err"}, 32'(mem_timeout_err), 32'd0);
    check_eq({tag, "_rst_halted"}, 32'(halted), 32'd0);
    model_reset();
    idle_inputs();
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    do_reset("init");

    // T1: load-use on rs gives a single bubble
    d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd1;
    rs_ID = 2'd1; use_rs_ID = 1'b1; rt_ID = 2'd2; use_rt_ID = 1'b1;
    probe("t1a");
    check_eq("t1a_lit", 32'(ctrl_obs), 32'b1000_010);
    advance();
    d_readM_EX = 1'b0; rs_ID = 2'd3; rt_ID = 2'd0;
    probe("t1b");
    check_eq("t1b_lit", 32'(ctrl_obs), 32'b0000_001);
    check_eq("t1b_stalls", 32'(stall_cycles), 32'd1);
    advance();

    // T2: mispredict beats load-use
    do_reset("t2");
    d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd2;
    rt_ID = 2'd2; use_rt_ID = 1'b1; mispredict_EX = 1'b1;
    probe("t2");
    check_eq("t2_lit", 32'(ctrl_obs), 32'b0000_111);
    advance();

    // T3: three data wait cycles, release on d_ready
    do_reset("t3");
    d_req_MEM = 1'b1; d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      probe("t3w");
      check_eq("t3w_lit", 32'(ctrl_obs), 32'b1111_000);
      advance();
    end
    d_ready = 1'b1;
    probe("t3r");
    check_eq("t3r_lit", 32'(ctrl_obs), 32'b0000_001);
    check_eq("t3r_stalls", 32'(stall_cycles), 32'd3);
    advance();
    idle_inputs();
    cycle_check("t3i");

    // T4: instruction wait long enough to hit the timeout
    do_reset("t4");
    i_req = 1'b1; i_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      probe("t4w");
      check_eq("t4w_err", 32'(mem_timeout_err), 32'd0);
      check_eq("t4w_lit", 32'(ctrl_obs), 32'b0000_100);
      advance();
    end
    i_ready = 1'b1;
    probe("t4r");
    check_eq("t4r_err", 32'(mem_timeout_err), 32'd1);
    check_eq("t4r_stalls", 32'(stall_cycles), 32'd16);
    advance();
    i_req = 1'b0;
    probe("t4s");
    check_eq("t4s_err", 32'(mem_timeout_err), 32'd1);
    advance();

    // T5: halt arrives during an instruction wait and holds
    do_reset("t5");
    i_req = 1'b1; i_ready = 1'b0;
    cycle_check("t5a");
    cycle_check("t5b");
    is_halted_WB = 1'b1;
    cycle_check("t5p");
    for (int i = 0; i < 12; i++) begin
      rand_inputs();
      is_halted_WB = 1'b0;
      probe("t5h");
      check_eq("t5h_halted", 32'(halted), 32'd1);
      check_eq("t5h_lit", 32'(ctrl_obs), 32'b1111_000);
      advance();
    end

    // T6: asynchronous reset in the middle of a data wait
    do_reset("t6a");
    d_req_MEM = 1'b1; d_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle_check("t6w");
    do_reset("t6");
    probe("t6r");
    check_eq("t6r_lit", 32'(ctrl_obs), 32'b0000_001);
    advance();

    // Randomized traffic with periodic resets
    for (int blk = 0; blk < 4; blk++) begin
      do_reset("rblk");
      for (int i = 0; i < 150; i++) begin
        rand_inputs();
        cycle_check("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
